// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, LSU and unified-memory signal bundle.
// master = arbiter view, slave = core + memory view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              icache_rd_i;
  logic [ADDR_W-1:0] icache_pc_i;
  logic [DATA_W-1:0] icache_instr_o;
  logic              icache_valid_o;
  logic              mem_read_en_i;
  logic              mem_write_en_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_write_data_i;
  logic [DATA_W-1:0] mem_read_data_o;
  logic              dcache_valid_o;
  logic              umem_req_o;
  logic              umem_we_o;
  logic [ADDR_W-1:0] umem_addr_o;
  logic [DATA_W-1:0] umem_wdata_o;
  logic [DATA_W-1:0] umem_rdata_i;
  logic              umem_ack_i;

  modport master (
    input  icache_rd_i, icache_pc_i,
    input  mem_read_en_i, mem_write_en_i,
    input  mem_addr_i, mem_write_data_i,
    input  umem_rdata_i, umem_ack_i,
    output icache_instr_o, icache_valid_o,
    output mem_read_data_o, dcache_valid_o,
    output umem_req_o, umem_we_o,
    output umem_addr_o, umem_wdata_o
  );

  modport slave (
    output icache_rd_i, icache_pc_i,
    output mem_read_en_i, mem_write_en_i,
    output mem_addr_i, mem_write_data_i,
    output umem_rdata_i, umem_ack_i,
    input  icache_instr_o, icache_valid_o,
    input  mem_read_data_o, dcache_valid_o,
    input  umem_req_o, umem_we_o,
    input  umem_addr_o, umem_wdata_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between fetch and LSU.
// Optional one-entry posted write buffer: define ARB_POSTED_WRITE_EN.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  unified_mem_arbiter_if.master bus,
  output logic                 arb_busy_o
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE, BUSY_I, BUSY_D, RESP
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ival_q, ival_d;
  logic              dval_q, dval_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              d_req;
  logic              force_i;
`ifdef ARB_POSTED_WRITE_EN
  logic              wb_vld_q, wb_vld_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              drain_q, drain_d;
`endif

  assign d_req   = bus.mem_read_en_i | bus.mem_write_en_i;
  assign force_i = bus.icache_rd_i &&
                   (starve_q >= CW'(STARVE_LIMIT));

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    instr_d  = instr_q;
    rdata_d  = rdata_q;
    ival_d   = 1'b0;
    dval_d   = 1'b0;
    starve_d = starve_q;
`ifdef ARB_POSTED_WRITE_EN
    wb_vld_d  = wb_vld_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    drain_d   = drain_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!bus.icache_rd_i) starve_d = '0;
`ifdef ARB_POSTED_WRITE_EN
        // Buffered store must reach memory before anything else.
        if (wb_vld_q) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = wb_addr_q;
          wdata_d = wb_data_q;
          drain_d = 1'b1;
          state_d = BUSY_D;
        end else if (!force_i && bus.mem_write_en_i) begin
          wb_vld_d  = 1'b1;
          wb_addr_d = bus.mem_addr_i;
          wb_data_d = bus.mem_write_data_i;
          dval_d    = 1'b1;
          state_d   = RESP;
          if (bus.icache_rd_i) starve_d = starve_q + CW'(1);
        end else
`endif
        if (force_i) begin
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = bus.icache_pc_i;
          starve_d = '0;
          state_d  = BUSY_I;
        end else if (d_req) begin
          req_d   = 1'b1;
          we_d    = bus.mem_write_en_i;
          addr_d  = bus.mem_addr_i;
          wdata_d = bus.mem_write_data_i;
          state_d = BUSY_D;
          if (bus.icache_rd_i) starve_d = starve_q + CW'(1);
        end else if (bus.icache_rd_i) begin
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = bus.icache_pc_i;
          starve_d = '0;
          state_d  = BUSY_I;
        end
      end
      BUSY_I: begin
        if (bus.umem_ack_i) begin
          instr_d = bus.umem_rdata_i;
          req_d   = 1'b0;
          ival_d  = 1'b1;
          state_d = RESP;
        end
      end
      BUSY_D: begin
        if (bus.umem_ack_i) begin
          if (!we_q) rdata_d = bus.umem_rdata_i;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = RESP;
`ifdef ARB_POSTED_WRITE_EN
          if (drain_q) begin
            wb_vld_d = 1'b0;
            drain_d  = 1'b0;
          end else begin
            dval_d = 1'b1;
          end
`else
          dval_d = 1'b1;
`endif
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      instr_q  <= '0;
      rdata_q  <= '0;
      ival_q   <= 1'b0;
      dval_q   <= 1'b0;
      starve_q <= '0;
`ifdef ARB_POSTED_WRITE_EN
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      drain_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      instr_q  <= instr_d;
      rdata_q  <= rdata_d;
      ival_q   <= ival_d;
      dval_q   <= dval_d;
      starve_q <= starve_d;
`ifdef ARB_POSTED_WRITE_EN
      wb_vld_q  <= wb_vld_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      drain_q   <= drain_d;
`endif
    end
  end

  assign bus.umem_req_o      = req_q;
  assign bus.umem_we_o       = we_q;
  assign bus.umem_addr_o     = addr_q;
  assign bus.umem_wdata_o    = wdata_q;
  assign bus.icache_instr_o  = instr_q;
  assign bus.icache_valid_o  = ival_q;
  assign bus.mem_read_data_o = rdata_q;
  assign bus.dcache_valid_o  = dval_q;
`ifdef ARB_POSTED_WRITE_EN
  assign arb_busy_o = (state_q != IDLE) | wb_vld_q;
`else
  assign arb_busy_o = (state_q != IDLE);
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed checks of fetch/LSU arbitration,
// starvation guard, stores, mid-transfer reset and posted writes.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   tests;
  int   fails;
  int   ack_delay;
  int   wcnt;
  logic [15:0] mem [0:255];

  unified_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .arb_busy_o(busy)
  );

  always #5 clk = ~clk;

  // memory responder: acks after ack_delay extra cycles
  initial begin
    bus.umem_ack_i   = 1'b0;
    bus.umem_rdata_i = '0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (bus.umem_req_o && !bus.umem_ack_i) begin
        if (wcnt >= ack_delay) begin
          bus.umem_ack_i   = 1'b1;
          bus.umem_rdata_i = mem[bus.umem_addr_o[7:0]];
          if (bus.umem_we_o)
            mem[bus.umem_addr_o[7:0]] = bus.umem_wdata_o;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        bus.umem_ack_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int budget, output logic iv,
                           output logic dv, output bit to);
    iv = 1'b0;
    dv = 1'b0;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.icache_valid_o || bus.dcache_valid_o) begin
        iv = bus.icache_valid_o;
        dv = bus.dcache_valid_o;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus.umem_req_o, bus.umem_we_o, bus.icache_valid_o,
         bus.dcache_valid_o, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 00000",
        {bus.umem_req_o, bus.umem_we_o, bus.icache_valid_o,
         bus.dcache_valid_o, busy});
    end
    tests++;
    if ({bus.umem_addr_o, bus.umem_wdata_o, bus.icache_instr_o,
         bus.mem_read_data_o} !== 64'h0) begin
      fails++;
      $display("FAIL reset_data got %h want 0",
        {bus.umem_addr_o, bus.umem_wdata_o, bus.icache_instr_o,
         bus.mem_read_data_o});
    end
    rst = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || bus.umem_req_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle got busy=%b req=%b want 0 0",
        busy, bus.umem_req_o);
    end
  endtask

  task automatic test_fetch();
    ack_delay = 0;
    mem[8'h04] = 16'h1A3F;
    bus.icache_pc_i = 16'h0004;
    bus.icache_rd_i = 1'b1;
    tick();
    tests++;
    if (bus.umem_req_o !== 1'b1 || bus.umem_we_o !== 1'b0 ||
        bus.umem_addr_o !== 16'h0004) begin
      fails++;
      $display("FAIL fetch_req got req=%b we=%b addr=%h want 1 0 0004",
        bus.umem_req_o, bus.umem_we_o, bus.umem_addr_o);
    end
    tick();
    tests++;
    if (bus.icache_valid_o !== 1'b1 || bus.icache_instr_o !== 16'h1A3F ||
        bus.dcache_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL fetch_resp got iv=%b instr=%h dv=%b want 1 1a3f 0",
        bus.icache_valid_o, bus.icache_instr_o, bus.dcache_valid_o);
    end
    bus.icache_rd_i = 1'b0;
    tick();
    tests++;
    if (bus.icache_valid_o !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL fetch_done got iv=%b busy=%b want 0 0",
        bus.icache_valid_o, busy);
    end
  endtask

  task automatic test_fetch_load();
    ack_delay = 2;
    mem[8'h09] = 16'hBEEF;
    mem[8'h10] = 16'h1234;
    bus.icache_pc_i = 16'h0010;
    bus.icache_rd_i = 1'b1;
    bus.mem_addr_i = 16'h0009;
    bus.mem_read_en_i = 1'b1;
    tick();
    tests++;
    if (bus.umem_req_o !== 1'b1 || bus.umem_addr_o !== 16'h0009) begin
      fails++;
      $display("FAIL fl_load_first got req=%b addr=%h want 1 0009",
        bus.umem_req_o, bus.umem_addr_o);
    end
    tick();
    tick();
    tick();
    tests++;
    if (bus.dcache_valid_o !== 1'b1 || bus.mem_read_data_o !== 16'hBEEF ||
        bus.icache_valid_o !== 1'b0 || bus.umem_req_o !== 1'b0) begin
      fails++;
      $display("FAIL fl_load_resp got dv=%b data=%h iv=%b req=%b want 1 beef 0 0",
        bus.dcache_valid_o, bus.mem_read_data_o,
        bus.icache_valid_o, bus.umem_req_o);
    end
    bus.mem_read_en_i = 1'b0;
    tick();
    tests++;
    if (bus.umem_req_o !== 1'b0) begin
      fails++;
      $display("FAIL fl_gap got req=%b want 0", bus.umem_req_o);
    end
    tick();
    tests++;
    if (bus.umem_req_o !== 1'b1 || bus.umem_addr_o !== 16'h0010) begin
      fails++;
      $display("FAIL fl_fetch_req got req=%b addr=%h want 1 0010",
        bus.umem_req_o, bus.umem_addr_o);
    end
    tick();
    tick();
    tick();
    tests++;
    if (bus.icache_valid_o !== 1'b1 || bus.icache_instr_o !== 16'h1234) begin
      fails++;
      $display("FAIL fl_fetch_resp got iv=%b instr=%h want 1 1234",
        bus.icache_valid_o, bus.icache_instr_o);
    end
    bus.icache_rd_i = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic iv, dv;
    bit to;
    ack_delay = 0;
    mem[8'h20] = 16'h5555;
    mem[8'h40] = 16'h7777;
    bus.mem_addr_i = 16'h0020;
    bus.mem_read_en_i = 1'b1;
    bus.icache_pc_i = 16'h0040;
    bus.icache_rd_i = 1'b1;
    for (int n = 0; n < 6; n++) begin
      wait_resp(8, iv, dv, to);
      tests++;
      if (to || iv !== (n == 4) || dv !== (n != 4)) begin
        fails++;
        $display("FAIL starve_grant%0d got iv=%b dv=%b to=%0d want iv=%b dv=%b",
          n, iv, dv, to, (n == 4), (n != 4));
      end
    end
    bus.mem_read_en_i = 1'b0;
    bus.icache_rd_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_store();
    int wecnt, dvcnt, vcyc;
    ack_delay = 3;
    wecnt = 0;
    dvcnt = 0;
    vcyc = 0;
    mem[8'h06] = 16'h0000;
    bus.mem_addr_i = 16'h0006;
    bus.mem_write_data_i = 16'h00FF;
    bus.mem_write_en_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.umem_req_o && bus.umem_we_o) wecnt++;
      if (bus.dcache_valid_o) begin
        dvcnt++;
        vcyc = c;
        bus.mem_write_en_i = 1'b0;
      end
    end
    tests++;
    if (wecnt != 4) begin
      fails++;
      $display("FAIL store_we_cycles got %0d want 4", wecnt);
    end
    tests++;
    if (dvcnt != 1) begin
      fails++;
      $display("FAIL store_valid_count got %0d want 1", dvcnt);
    end
`ifdef ARB_POSTED_WRITE_EN
    tests++;
    if (vcyc != 1) begin
      fails++;
      $display("FAIL store_valid_cycle got %0d want 1", vcyc);
    end
`else
    tests++;
    if (vcyc != 5) begin
      fails++;
      $display("FAIL store_valid_cycle got %0d want 5", vcyc);
    end
`endif
    tests++;
    if (bus.mem_read_data_o !== 16'h5555 || mem[8'h06] !== 16'h00FF) begin
      fails++;
      $display("FAIL store_data got rdata=%h mem=%h want 5555 00ff",
        bus.mem_read_data_o, mem[8'h06]);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL store_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic iv, dv;
    bit to;
    ack_delay = 3;
    mem[8'h22] = 16'h6A6A;
    bus.mem_addr_i = 16'h0022;
    bus.mem_read_en_i = 1'b1;
    tick();
    tick();
    tests++;
    if (bus.umem_req_o !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rmid_busy got req=%b busy=%b want 1 1",
        bus.umem_req_o, busy);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.umem_req_o, busy, bus.dcache_valid_o} !== 3'b0 ||
        bus.mem_read_data_o !== 16'h0) begin
      fails++;
      $display("FAIL rmid_async got req=%b busy=%b dv=%b data=%h want 0 0 0 0",
        bus.umem_req_o, busy, bus.dcache_valid_o, bus.mem_read_data_o);
    end
    tick();
    tests++;
    if (bus.dcache_valid_o !== 1'b0 || bus.umem_req_o !== 1'b0) begin
      fails++;
      $display("FAIL rmid_hold got dv=%b req=%b want 0 0",
        bus.dcache_valid_o, bus.umem_req_o);
    end
    rst = 1'b0;
    wait_resp(12, iv, dv, to);
    tests++;
    if (to || dv !== 1'b1 || bus.mem_read_data_o !== 16'h6A6A) begin
      fails++;
      $display("FAIL rmid_retry got to=%0d dv=%b data=%h want 0 1 6a6a",
        to, dv, bus.mem_read_data_o);
    end
    bus.mem_read_en_i = 1'b0;
    tick();
    tick();
  endtask

`ifdef ARB_POSTED_WRITE_EN
  task automatic test_posted_write();
    logic prev;
    logic wes [$];
    bit seen;
    ack_delay = 1;
    mem[8'h30] = 16'h0000;
    bus.mem_addr_i = 16'h0030;
    bus.mem_write_data_i = 16'hCAFE;
    bus.mem_write_en_i = 1'b1;
    tick();
    tests++;
    if (bus.dcache_valid_o !== 1'b1 || bus.umem_req_o !== 1'b0 ||
        busy !== 1'b1) begin
      fails++;
      $display("FAIL pw_early got dv=%b req=%b busy=%b want 1 0 1",
        bus.dcache_valid_o, bus.umem_req_o, busy);
    end
    bus.mem_write_en_i = 1'b0;
    bus.mem_read_en_i = 1'b1;
    prev = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.umem_req_o && !prev) wes.push_back(bus.umem_we_o);
      prev = bus.umem_req_o;
      if (bus.dcache_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (wes.size() != 2 || wes[0] !== 1'b1 || wes[1] !== 1'b0) begin
      fails++;
      $display("FAIL pw_order got n=%0d want drain write then read",
        wes.size());
    end
    tests++;
    if (!seen || bus.mem_read_data_o !== 16'hCAFE) begin
      fails++;
      $display("FAIL pw_load got seen=%0d data=%h want 1 cafe",
        seen, bus.mem_read_data_o);
    end
    bus.mem_read_en_i = 1'b0;
    tick();
    tick();
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    ack_delay = 0;
    rst = 1'b1;
    bus.icache_rd_i = 1'b0;
    bus.icache_pc_i = '0;
    bus.mem_read_en_i = 1'b0;
    bus.mem_write_en_i = 1'b0;
    bus.mem_addr_i = '0;
    bus.mem_write_data_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    test_reset();
    test_fetch();
    test_fetch_load();
    test_starvation();
    test_store();
    test_reset_mid();
`ifdef ARB_POSTED_WRITE_EN
    test_posted_write();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
